// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the uart_basic start/busy handshake, bundled for uart_tx_arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   grant;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic                 abort;

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, grant, tx_start, tx_data, abort
    );

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, grant, tx_start, tx_data, abort
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter feeding one uart_basic transmitter from NUM_REQ byte streams,
// with a stall timeout that revokes the lock of an owner that stops supplying bytes.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int STALL_TIMEOUT = 1_000_000
) (
    input  logic             clk_100M,
    input  logic             reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(STALL_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STALL_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HOLD    = 3'd1,
        START   = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic               tx_start_q, tx_start_d;
    logic               abort_q, abort_d;
    logic               last_q, last_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic               own_valid_s;
    logic               own_last_s;
    logic [7:0]         own_data_s;
    logic [NUM_REQ-1:0] hi_mask_s;
    logic [IDX_W-1:0]   rr_idx_s;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_REQ-1:0] m);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = m[i] ? IDX_W'(i) : idx;
        end
        return idx;
    endfunction

    // Owner's byte lane, selected by the one-hot lock so no index decode is needed.
    always_comb begin
        own_valid_s = 1'b0;
        own_last_s  = 1'b0;
        own_data_s  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            own_valid_s = own_valid_s | (grant_q[i] & bus.req_valid[i]);
            own_last_s  = own_last_s  | (grant_q[i] & bus.req_last[i]);
            own_data_s  = own_data_s  | ({8{grant_q[i]}} & bus.req_data[8*i +: 8]);
        end
    end

    // Round-robin pick: lowest valid index above last_grant, else wrap to the lowest valid index.
    always_comb begin
        hi_mask_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hi_mask_s[i] = bus.req_valid[i] & (IDX_W'(i) > last_grant_q);
        end
        rr_idx_s = (|hi_mask_s) ? lowest_idx(hi_mask_s) : lowest_idx(bus.req_valid);
    end

    // Next-state and next-output computation for the lock/transmit FSM.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        tx_start_d   = 1'b0;
        abort_d      = 1'b0;
        last_d       = last_q;
        tx_data_d    = tx_data_q;
        stall_cnt_d  = stall_cnt_q;
        case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    owner_d     = rr_idx_s;
                    grant_d     = {{(NUM_REQ-1){1'b0}}, 1'b1} << rr_idx_s;
                    stall_cnt_d = '0;
                    state_d     = HOLD;
                end else begin
                    grant_d = '0;
                end
            end
            HOLD: begin
                if (own_valid_s) begin
                    tx_data_d   = own_data_s;
                    last_d      = own_last_s;
                    stall_cnt_d = '0;
                    tx_start_d  = 1'b1;
                    state_d     = START;
                end else if (stall_cnt_q == CNT_MAX) begin
                    abort_d      = 1'b1;
                    last_grant_d = owner_q;
                    grant_d      = '0;
                    stall_cnt_d  = '0;
                    state_d      = IDLE;
                end else begin
                    stall_cnt_d = stall_cnt_q + CNT_W'(1);
                end
            end
            START: begin
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_LO;
                end else begin
                    state_d = WAIT_HI;
                end
            end
            WAIT_LO: begin
                if (!bus.tx_busy) begin
                    if (last_q) begin
                        last_grant_d = owner_q;
                        grant_d      = '0;
                        state_d      = IDLE;
                    end else begin
                        state_d = HOLD;
                    end
                end else begin
                    state_d = WAIT_LO;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any lock immediately.
    always_ff @(posedge clk_100M) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            last_grant_q <= LAST_RST;
            tx_start_q   <= 1'b0;
            abort_q      <= 1'b0;
            last_q       <= 1'b0;
            tx_data_q    <= 8'h00;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            tx_start_q   <= tx_start_d;
            abort_q      <= abort_d;
            last_q       <= last_d;
            tx_data_q    <= tx_data_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bus.req_ready = (state_q == HOLD) ? grant_q : '0;
    assign bus.grant     = grant_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.abort     = abort_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester drivers, a uart_basic busy model,
// and a monitor that checks every tx_start/abort against queued expectations.
module tb_uart_tx_arbiter;
    localparam int NREQ = 2;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         dly;
    } pkt_t;

    typedef struct {
        bit         is_abort;
        logic [7:0] data;
        logic [1:0] grant;
        int         ref_kind;   // 0: no timing check, 1: cycles since busy fell, 2: cycles since HOLD entered
        int         gap;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic tx_busy_s;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   issued = 0;
    int   n_start = 0;
    int   ohv = 0;
    int   busy_len = 10;
    int   busy_left = 0;
    int   last_fall = 0;
    int   hold_cyc = 0;
    bit   rand_mode = 1'b0;
    logic [1:0] prev_rdy = 2'b00;
    exp_t exp_q[$];

    uart_tx_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    uart_tx_arbiter #(.NUM_REQ(NREQ), .STALL_TIMEOUT(8)) dut (
        .clk_100M (clk),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    for (genvar g = 0; g < NREQ; g++) begin : g_drv
        logic       v;
        logic       l;
        logic [7:0] d;
        bit         act;
        bit         got;
        int         n;
        pkt_t       p;
        pkt_t       pq[$];
        logic [7:0] sb[$];
        initial begin
            v = 1'b0; l = 1'b0; d = 8'h00; act = 1'b0;
            forever begin
                @(posedge clk); #1;
                if (pq.size() != 0) begin
                    act = 1'b1;
                    p = pq.pop_front();
                    if (p.dly > 0) begin
                        repeat (p.dly) @(posedge clk);
                        #1;
                    end
                    v = 1'b1; d = p.data; l = p.last;
                    got = 1'b0; n = 0;
                    while (!got && n < 400) begin
                        @(negedge clk);
                        n++;
                        got = bus.req_ready[g];
                    end
                    check($sformatf("accept_req%0d", g), int'(got), 1);
                    @(posedge clk); #1;
                    v = 1'b0; l = 1'b0;
                    if (got && rand_mode) sb.push_back(p.data);
                    act = 1'b0;
                end
            end
        end
    end

    assign bus.req_valid = {g_drv[1].v, g_drv[0].v};
    assign bus.req_last  = {g_drv[1].l, g_drv[0].l};
    assign bus.req_data  = {g_drv[1].d, g_drv[0].d};
    assign bus.tx_busy   = tx_busy_s;

    // uart_basic model: busy from the cycle after tx_start for busy_len cycles
    initial begin
        tx_busy_s = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_start) begin
                busy_left = busy_len;
                tx_busy_s = 1'b1;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    tx_busy_s = 1'b0;
                    last_fall = cyc;
                end
            end
        end
    end

    task automatic pop_check(input bit is_abort);
        exp_t e;
        check(is_abort ? "abort_expected" : "start_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("event_kind", int'(is_abort), int'(e.is_abort));
            check("event_grant", int'(bus.grant), int'(e.grant));
            if (!is_abort) check("tx_data", int'(bus.tx_data), int'(e.data));
            if (e.ref_kind == 1) check("start_after_busy_fall", cyc - last_fall, e.gap);
            if (e.ref_kind == 2) check("abort_after_hold", cyc - hold_cyc, e.gap);
        end
    endtask

    // Monitor: one-hot invariants every cycle, scoreboard pop on each DUT event
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (!$onehot0(bus.grant) || !$onehot0(bus.req_ready)) ohv++;
                if (bus.req_ready != 2'b00 && prev_rdy == 2'b00) hold_cyc = cyc;
                if (bus.tx_start) begin
                    n_start++;
                    if (rand_mode) begin
                        check("rand_grant_onehot", int'($onehot(bus.grant)), 1);
                        if (bus.grant[0]) begin
                            check("rand_sb0_nonempty", int'(g_drv[0].sb.size() != 0), 1);
                            if (g_drv[0].sb.size() != 0) check("rand_data_req0", int'(bus.tx_data), int'(g_drv[0].sb.pop_front()));
                        end else begin
                            check("rand_sb1_nonempty", int'(g_drv[1].sb.size() != 0), 1);
                            if (g_drv[1].sb.size() != 0) check("rand_data_req1", int'(bus.tx_data), int'(g_drv[1].sb.pop_front()));
                        end
                    end else begin
                        pop_check(1'b0);
                    end
                end
                if (bus.abort) begin
                    if (rand_mode) check("rand_unexpected_abort", int'(bus.abort), 0);
                    else pop_check(1'b1);
                end
            end
            prev_rdy = bus.req_ready;
        end
    end

    task automatic add_byte(input int r, input logic [7:0] d, input logic last, input int dly);
        pkt_t p;
        p.data = d; p.last = last; p.dly = dly;
        if (r == 0) g_drv[0].pq.push_back(p);
        else        g_drv[1].pq.push_back(p);
        issued++;
    endtask

    task automatic expect_ev(input bit ab, input logic [7:0] d, input logic [1:0] g, input int rk, input int gap);
        exp_t e;
        e.is_abort = ab; e.data = d; e.grant = g; e.ref_kind = rk; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic chk_zero(input string nm);
        check({nm, "_grant"},    int'(bus.grant),     0);
        check({nm, "_ready"},    int'(bus.req_ready), 0);
        check({nm, "_tx_start"}, int'(bus.tx_start),  0);
        check({nm, "_abort"},    int'(bus.abort),     0);
        check({nm, "_tx_data"},  int'(bus.tx_data),   0);
    endtask

    task automatic drain(input string nm, input int lim);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || g_drv[0].pq.size() != 0 || g_drv[1].pq.size() != 0 ||
                g_drv[0].act || g_drv[1].act || g_drv[0].sb.size() != 0 || g_drv[1].sb.size() != 0 ||
                bus.tx_busy || bus.grant != 2'b00) && n < lim) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_pending"}, exp_q.size() + g_drv[0].sb.size() + g_drv[1].sb.size(), 0);
        check({nm, "_idle_grant"}, int'(bus.grant), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        int sent;
        int plen;
        logic lst;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;

        // both requesters, single-byte packets: req 0 wins first
        add_byte(0, 8'h41, 1'b1, 0);
        add_byte(1, 8'h42, 1'b1, 0);
        expect_ev(1'b0, 8'h41, 2'b01, 0, 0);
        expect_ev(1'b0, 8'h42, 2'b10, 0, 0);
        drain("rr_basic", 400);

        // locked 3-byte packet from req 0 while req 1 waits; busy-limited spacing
        add_byte(0, 8'h10, 1'b0, 0);
        add_byte(0, 8'h11, 1'b0, 0);
        add_byte(0, 8'h12, 1'b1, 0);
        add_byte(1, 8'h20, 1'b1, 0);
        expect_ev(1'b0, 8'h10, 2'b01, 0, 0);
        expect_ev(1'b0, 8'h11, 2'b01, 1, 2);
        expect_ev(1'b0, 8'h12, 2'b01, 1, 2);
        expect_ev(1'b0, 8'h20, 2'b10, 0, 0);
        drain("lock", 600);

        // stall timeout: req 0 stops mid-packet, req 1 gets the line after abort
        add_byte(0, 8'h55, 1'b0, 0);
        add_byte(1, 8'h66, 1'b1, 0);
        expect_ev(1'b0, 8'h55, 2'b01, 0, 0);
        expect_ev(1'b1, 8'h00, 2'b00, 2, 8);
        expect_ev(1'b0, 8'h66, 2'b10, 0, 0);
        drain("stall", 600);

        // reset while waiting for busy to fall mid-packet
        add_byte(0, 8'h60, 1'b0, 0);
        expect_ev(1'b0, 8'h60, 2'b01, 0, 0);
        n = 0;
        while (!bus.tx_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_start_before_reset", int'(bus.tx_start), 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_zero("midpkt_reset");
        reset = 1'b0;
        n = 0;
        while (bus.tx_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("busy_done_after_reset", int'(bus.tx_busy), 0);
        add_byte(1, 8'h70, 1'b1, 0);
        expect_ev(1'b0, 8'h70, 2'b10, 0, 0);
        drain("after_reset", 400);

        // random packet traffic, 10k bytes total, fast transmitter
        busy_len  = 2;
        rand_mode = 1'b1;
        for (int r = 0; r < NREQ; r++) begin
            sent = 0;
            while (sent < 5000) begin
                plen = int'($urandom_range(1, 4));
                for (int b = 0; b < plen && sent < 5000; b++) begin
                    lst = (b == plen - 1) || (sent == 4999);
                    add_byte(r, 8'($urandom), lst, int'($urandom_range(0, 2)));
                    sent++;
                end
            end
        end
        drain("random", 90000);

        check("tx_start_count", n_start, issued);
        check("onehot_violations", ohv, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
